piso_tx_sequencer: RTL and testbench

Controller that sequences the parallel-in/serial-out shift register for serial transmission. It accepts a WIDTH-bit word through a valid/ready handshake, loads it into the internal shift register, and shifts it out one bit per DIV clock cycles, LSB- or MSB-first. It signals end-of-frame with a one-cycle `done` pulse. It sits between a word producer and a serial line or consumer, and owns all load, shift and clear sequencing of the shift register.

---
 rtl/piso_tx_sequencer.sv | 162 ++++++++++++++++
 tb/tb_piso_tx_sequencer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/piso_tx_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : piso_tx_sequencer
// Purpose  : Sequences a parallel-in/serial-out shift register. A WIDTH-bit
//            word is accepted over a valid/ready handshake, then shifted out
//            one bit every DIV clocks (LSB- or MSB-first), followed by a
//            single-cycle done pulse.
// Ports    : clk       - clock, all state changes on rising edge
//            clr       - asynchronous active-high reset
//            in_valid  - producer offers in_data
//            in_data   - word to transmit (sampled on acceptance only)
//            in_ready  - block can accept a word
//            ser_out   - current serial bit (0 when not shifting)
//            ser_valid - ser_out carries a frame bit
//            busy      - frame in progress (SHIFT or DONE)
//            done      - one-cycle end-of-frame pulse
// Revision : 1.0 - initial release
// ============================================================================
module piso_tx_sequencer #(
    parameter int WIDTH     = 4,
    parameter int DIV       = 1,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             busy,
    output logic             done
);

    // Counter widths; the divider counter keeps at least one bit so that
    // DIV=1 still has a legal (constant-zero) register.
    localparam int c_BW = $clog2(WIDTH);
    localparam int c_DW = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [c_BW-1:0] c_BIT_LAST = c_BW'(WIDTH - 1);
    localparam logic [c_DW-1:0] c_DIV_LAST = c_DW'(DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WIDTH-1:0]  r_shreg;
    logic [WIDTH-1:0]  w_shreg_nxt;
    logic [c_BW-1:0]   r_bit_cnt;
    logic [c_BW-1:0]   w_bit_cnt_nxt;
    logic [c_DW-1:0]   r_div_cnt;
    logic [c_DW-1:0]   w_div_cnt_nxt;

    logic              w_accept;
    logic              w_div_last;
    logic              w_bit_last;
    logic [WIDTH-1:0]  w_shreg_shifted;
    logic              w_out_bit;

    // ------------------------------------------------------------------------
    // Direction-dependent shift and output tap. The register always moves
    // toward the tap end with zero fill, so the tap holds the next bit.
    // ------------------------------------------------------------------------
    generate
        if (LSB_FIRST) begin : g_lsb_first
            assign w_shreg_shifted = r_shreg >> 1;
            assign w_out_bit       = r_shreg[0];
        end else begin : g_msb_first
            assign w_shreg_shifted = r_shreg << 1;
            assign w_out_bit       = r_shreg[WIDTH-1];
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Moore outputs. in_ready is gated by clr so it reads 0 for the whole
    // time reset is held, not just after the register has been cleared.
    // ------------------------------------------------------------------------
    assign in_ready   = (r_state == ST_IDLE) & ~clr;
    assign ser_valid  = (r_state == ST_SHIFT);
    assign ser_out    = ser_valid & w_out_bit;
    assign busy       = (r_state != ST_IDLE);
    assign done       = (r_state == ST_DONE);

    assign w_accept   = in_valid & in_ready;
    assign w_div_last = (r_div_cnt == c_DIV_LAST);
    assign w_bit_last = (r_bit_cnt == c_BIT_LAST);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state   <= ST_IDLE;
            r_shreg   <= '0;
            r_bit_cnt <= '0;
            r_div_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_shreg   <= w_shreg_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_div_cnt <= w_div_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_shreg_nxt   = r_shreg;
        w_bit_cnt_nxt = r_bit_cnt;
        w_div_cnt_nxt = r_div_cnt;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt   = ST_SHIFT;
                    w_shreg_nxt   = in_data;
                    w_bit_cnt_nxt = '0;
                    w_div_cnt_nxt = '0;
                end
            end

            ST_SHIFT: begin
                if (w_div_last) begin
                    if (w_bit_last) begin
                        // Last bit period ends: clear the register and park
                        // the counters so the next frame starts from zero.
                        w_state_nxt   = ST_DONE;
                        w_shreg_nxt   = '0;
                        w_bit_cnt_nxt = '0;
                        w_div_cnt_nxt = '0;
                    end else begin
                        w_shreg_nxt   = w_shreg_shifted;
                        w_bit_cnt_nxt = r_bit_cnt + c_BW'(1);
                        w_div_cnt_nxt = '0;
                    end
                end else begin
                    w_div_cnt_nxt = r_div_cnt + c_DW'(1);
                end
            end

            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end

            default: begin
                // Unreachable encoding: recover to a clean idle state.
                w_state_nxt   = ST_IDLE;
                w_shreg_nxt   = '0;
                w_bit_cnt_nxt = '0;
                w_div_cnt_nxt = '0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_piso_tx_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_piso_tx_sequencer
// Purpose  : Self-checking bench for piso_tx_sequencer. Three instances
//            (LSB-first DIV=1, LSB-first DIV=3, MSB-first DIV=1) run directed
//            frames, backpressure and abort, then randomized traffic. A
//            frame-timeline reference model predicts every output each cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_piso_tx_sequencer;

    localparam int c_W           = 4;
    localparam int c_NI          = 3;
    localparam int c_RAND_CYCLES = 3000;

    logic             clk = 1'b0;
    logic             clr = 1'b0;
    logic [c_NI-1:0]  in_valid = '0;
    logic [c_W-1:0]   in_data [c_NI];
    logic [c_NI-1:0]  in_ready;
    logic [c_NI-1:0]  ser_out;
    logic [c_NI-1:0]  ser_valid;
    logic [c_NI-1:0]  busy;
    logic [c_NI-1:0]  done;

    always #5 clk = ~clk;

    piso_tx_sequencer #(.WIDTH(c_W), .DIV(1), .LSB_FIRST(1'b1)) u_dut_a (
        .clk(clk), .clr(clr), .in_valid(in_valid[0]), .in_data(in_data[0]),
        .in_ready(in_ready[0]), .ser_out(ser_out[0]), .ser_valid(ser_valid[0]),
        .busy(busy[0]), .done(done[0])
    );

    piso_tx_sequencer #(.WIDTH(c_W), .DIV(3), .LSB_FIRST(1'b1)) u_dut_b (
        .clk(clk), .clr(clr), .in_valid(in_valid[1]), .in_data(in_data[1]),
        .in_ready(in_ready[1]), .ser_out(ser_out[1]), .ser_valid(ser_valid[1]),
        .busy(busy[1]), .done(done[1])
    );

    piso_tx_sequencer #(.WIDTH(c_W), .DIV(1), .LSB_FIRST(1'b0)) u_dut_c (
        .clk(clk), .clr(clr), .in_valid(in_valid[2]), .in_data(in_data[2]),
        .in_ready(in_ready[2]), .ser_out(ser_out[2]), .ser_valid(ser_valid[2]),
        .busy(busy[2]), .done(done[2])
    );

    // Reference model: each instance is described only by how many cycles
    // have elapsed since its acceptance edge (age, -1 when idle) and the word
    // it took. Outputs follow directly from the frame timeline.
    int             divs [c_NI] = '{1, 3, 1};
    bit             lsbf [c_NI] = '{1'b1, 1'b1, 1'b0};
    int             age  [c_NI] = '{-1, -1, -1};
    logic [c_W-1:0] word [c_NI];
    bit             pending [c_NI] = '{1'b0, 1'b0, 1'b0};

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < c_NI; i++) age[i] = -1;
    endfunction

    // Called right after each rising edge with the inputs that were stable
    // across that edge.
    function automatic void model_step();
        for (int i = 0; i < c_NI; i++) begin
            if (clr) begin
                age[i] = -1;
            end else if (age[i] < 0) begin
                if (in_valid[i]) begin
                    age[i]     = 1;
                    word[i]    = in_data[i];
                    pending[i] = 1'b0;
                end
            end else begin
                age[i]++;
                if (age[i] > c_W * divs[i] + 1) age[i] = -1;
            end
        end
    endfunction

    task automatic check_all(input string when);
        for (int i = 0; i < c_NI; i++) begin
            int   k;
            logic e_rdy, e_sv, e_so, e_busy, e_done;
            e_rdy  = (age[i] < 0) && !clr;
            e_sv   = (age[i] >= 1) && (age[i] <= c_W * divs[i]);
            e_so   = 1'b0;
            if (e_sv) begin
                k    = (age[i] - 1) / divs[i];
                e_so = lsbf[i] ? word[i][k] : word[i][c_W-1-k];
            end
            e_done = (age[i] == c_W * divs[i] + 1);
            e_busy = (age[i] >= 1);
            chk($sformatf("%s/u%0d in_ready", when, i),  32'(in_ready[i]),  32'(e_rdy));
            chk($sformatf("%s/u%0d ser_valid", when, i), 32'(ser_valid[i]), 32'(e_sv));
            chk($sformatf("%s/u%0d ser_out", when, i),   32'(ser_out[i]),   32'(e_so));
            chk($sformatf("%s/u%0d busy", when, i),      32'(busy[i]),      32'(e_busy));
            chk($sformatf("%s/u%0d done", when, i),      32'(done[i]),      32'(e_done));
        end
    endtask

    // One clock: model follows the edge, outputs are checked 1 time unit
    // later, and control returns at the falling edge for the next drive.
    task automatic cycle(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < c_NI; i++) begin
            in_data[i] = '0;
            word[i]    = '0;
        end

        // Reset asserted mid-cycle ahead of the first edge.
        #2 clr = 1'b1;
        model_clear();
        #1 check_all("reset_async");
        @(negedge clk);
        cycle("reset_hold");
        clr = 1'b0;
        #1 check_all("reset_release");
        @(negedge clk);

        // Directed frames: 1010 LSB-first, 0001 at DIV=3, 1100 MSB-first.
        in_valid   = 3'b111;
        in_data[0] = 4'b1010;
        in_data[1] = 4'b0001;
        in_data[2] = 4'b1100;
        cycle("frame_accept");
        // Backpressure: instance a keeps offering 0110 during its frame.
        in_data[0] = 4'b0110;
        in_valid[1] = 1'b0;
        in_valid[2] = 1'b0;
        repeat (5) cycle("frame");
        cycle("bp_accept");
        in_valid[0] = 1'b0;
        repeat (14) cycle("bp_frame");

        // Abort during bit 2 of a 1111 frame, then a clean 1111 frame.
        in_valid = 3'b111;
        for (int i = 0; i < c_NI; i++) in_data[i] = 4'b1111;
        cycle("abort_accept");
        in_valid = 3'b000;
        repeat (2) cycle("abort_pre");
        clr = 1'b1;
        model_clear();
        #1 check_all("abort_async");
        @(negedge clk);
        cycle("abort_hold");
        clr = 1'b0;
        in_valid = 3'b111;
        cycle("reframe_accept");
        in_valid = 3'b000;
        repeat (14) cycle("reframe");

        // Randomized traffic with occasional resets. A word once offered is
        // held until it is taken.
        for (int n = 0; n < c_RAND_CYCLES; n++) begin
            for (int i = 0; i < c_NI; i++) begin
                if (!pending[i]) begin
                    in_valid[i] = ($urandom_range(0, 2) != 0);
                    in_data[i]  = c_W'($urandom);
                    pending[i]  = in_valid[i];
                end
            end
            if ($urandom_range(0, 99) == 0) begin
                clr = 1'b1;
                model_clear();
                #1 check_all("rand_clr_async");
                @(negedge clk);
                cycle("rand_clr");
                clr = 1'b0;
            end else begin
                cycle("rand");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
